obstacle_scheduler: RTL

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler_pkg.sv | 26 ++
 rtl/lfsr10.sv | 28 ++
 rtl/obstacle_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// Shared types for the obstacle scheduler.
// State/mode encodings and the LFSR seed.
package obstacle_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_EASY    = 2'd0,
    M_NORMAL  = 2'd1,
    M_EXTREME = 2'd2
  } mode_t;

  localparam logic [9:0] LFSR_SEED = 10'h001;

  // Mode 3 plays as extreme.
  function automatic mode_t norm_mode(
    input logic [1:0] m
  );
    return (m == 2'd3) ? M_EXTREME : mode_t'(m);
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR, taps bit9^bit8.
// Holds unless advance; zero reloads the seed.
module lfsr10
  import obstacle_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [9:0] q
);

  logic [9:0] nxt;

  always_comb begin
    nxt = {q[8:0], q[9] ^ q[8]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (q == '0) begin
      q <= LFSR_SEED;
    end else if (advance) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game obstacle spawn scheduler: FSM, gap
// counter, trigger select, valid/ready spawn.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int EASY_GAP    = 8,
  parameter int NORMAL_GAP  = 4,
  parameter int EXTREME_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       tick,
  input  logic [1:0] mode,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [1:0] spawn_lane,
  output logic [7:0] spawn_count,
  output logic [1:0] state
);

  state_t      st_q;
  state_t      st_d;
  mode_t       mode_q;
  logic [3:0]  gap;
  logic [4:0]  gap_sum;
  logic [4:0]  gap_lim;
  logic [9:0]  lfsr_q;
  logic        trig;
  logic        tick_run;
  logic        accept;
  logic        enter;
  logic        fire;

  lfsr10 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (tick_run),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Conditions are disjoint; stop wins.
  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      stop:
        st_d = S_IDLE;
      !stop && st_q == S_IDLE && start:
        st_d = S_RUN;
      !stop && st_q == S_RUN && pause:
        st_d = S_PAUSED;
      !stop && st_q == S_PAUSED && !pause:
        st_d = S_RUN;
      default:
        st_d = st_q;
    endcase
  end

  always_comb begin
    state = st_q;
  end

  always_comb begin
    trig    = 1'b0;
    gap_lim = 5'(EXTREME_GAP);
    unique case (mode_q)
      M_EASY: begin
        trig    = lfsr_q[1];
        gap_lim = 5'(EASY_GAP);
      end
      M_NORMAL: begin
        trig    = lfsr_q[9] | lfsr_q[3];
        gap_lim = 5'(NORMAL_GAP);
      end
      default: begin
        trig    = lfsr_q[9] | lfsr_q[3]
                | lfsr_q[7];
        gap_lim = 5'(EXTREME_GAP);
      end
    endcase
  end

  always_comb begin
    tick_run = (st_q == S_RUN) & tick
             & ~spawn_valid;
    accept   = spawn_valid & spawn_ready
             & ~stop;
    enter    = (st_q == S_IDLE) & start
             & ~stop;
    gap_sum  = {1'b0, gap} + 5'd1;
    fire     = tick_run & trig
             & (gap_sum >= gap_lim);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spawn_valid <= 1'b0;
      spawn_lane  <= 2'd0;
      spawn_count <= 8'd0;
      gap         <= 4'd0;
      mode_q      <= M_EASY;
    end else begin
      if (stop || accept) begin
        spawn_valid <= 1'b0;
      end else if (fire) begin
        spawn_valid <= 1'b1;
        spawn_lane  <= {lfsr_q[7], lfsr_q[5]};
      end
      if (enter || accept) begin
        gap <= 4'd0;
      end else if (tick_run) begin
        gap <= (gap == 4'd15) ? 4'd15
                              : gap + 4'd1;
      end
      if (enter) begin
        spawn_count <= 8'd0;
        mode_q      <= norm_mode(mode);
      end else if (accept) begin
        spawn_count <= spawn_count + 8'd1;
      end
    end
  end

endmodule
